// File: rtl/layer1_input_sequencer_pkg.sv
// Shared definitions for the Layer 1 input sequencer: FSM state encoding,
// default frame geometry and the TRUE/FALSE constants used across Layer 1.
package layer1_input_sequencer_pkg;

    localparam int DEFAULT_NUM_PIXELS = 784;
    localparam int DEFAULT_ADDR_W     = 10;
    localparam int DEFAULT_FIFO_DEPTH = 1024;
    localparam int DEFAULT_PIXEL_W    = 8;
    localparam int DEFAULT_THRESHOLD  = 128;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        READY,
        DONE
    } seqState_t;

endpackage

// File: rtl/layer1_input_sequencer_index_fifo.sv
// First-word fall-through FIFO of active pixel indices. The head is held in a
// register so it reads as zero after reset and holds its value when drained.
module layer1_input_sequencer_index_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 1024,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdNext;
    logic [CNT_W-1:0] countNext;
    logic             doPush;
    logic             doPop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign doPush    = push && !full;
    assign doPop     = pop && !empty;
    assign rdNext    = rdPtr + PTR_W'(doPop);
    assign countNext = count + CNT_W'(doPush) - CNT_W'(doPop);

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    // When the next head is the slot being written this cycle, bypass din;
    // when the FIFO drains, keep the last head visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            dout  <= '0;
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            dout  <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            rdPtr <= rdNext;
            count <= countNext;
            if (doPush && (rdNext == wrPtr)) begin
                dout <= din;
            end else if (countNext != '0) begin
                dout <= mem[rdNext];
            end
        end
    end

endmodule

// File: rtl/layer1_input_sequencer.sv
// Layer 1 front end: thresholds a pixel stream, queues active pixel indices and
// hands them to Layer 1, yielding to config writes. STREAM_EN overlaps pops with the scan.
module layer1_input_sequencer
    import layer1_input_sequencer_pkg::*;
#(
    parameter int NUM_PIXELS = DEFAULT_NUM_PIXELS,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int PIXEL_W    = DEFAULT_PIXEL_W,
    parameter int THRESHOLD  = DEFAULT_THRESHOLD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               pixel_valid,
    input  logic [PIXEL_W-1:0] pixel_data,
    output logic               pixel_ready,
    input  logic               cfg_busy,
    input  logic               dequeue,
    output logic [ADDR_W-1:0]  queue_out,
    output logic               queue_empty,
    output logic               inputs_ready,
    output logic               frame_done,
    output logic               empty_frame,
    output logic               overflow_err
);

    localparam int IDX_W = $clog2(NUM_PIXELS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    seqState_t        state;
    logic [IDX_W-1:0] pixelIdx;
    logic             pushedAny;
    logic             accept;
    logic             pushReq;
    logic             pushAccepted;
    logic             popReq;
    logic             popAllowed;
    logic             fifoClear;
    logic             fifoEmpty;
    logic             fifoFull;
    logic [CNT_W-1:0] fifoCount;
    logic [CNT_W-1:0] countAfter;

    assign pixel_ready  = (state == SCAN) && !cfg_busy;
    assign accept       = pixel_valid && pixel_ready;
    assign pushReq      = accept && (pixel_data >= PIXEL_W'(THRESHOLD));
    assign pushAccepted = pushReq && !fifoFull;
    assign fifoClear    = (state == IDLE) && frame_start && !cfg_busy;

`ifdef STREAM_EN
    assign popAllowed  = (state == READY) || (state == SCAN);
    assign queue_empty = fifoEmpty && (state != SCAN);
`else
    assign popAllowed  = (state == READY);
    assign queue_empty = fifoEmpty || (state != READY);
`endif

    assign inputs_ready = popAllowed && !fifoEmpty && !cfg_busy;
    assign popReq       = dequeue && inputs_ready;
    assign countAfter   = fifoCount + CNT_W'(pushAccepted) - CNT_W'(popReq);

    layer1_input_sequencer_index_fifo #(
        .WIDTH(ADDR_W),
        .DEPTH(FIFO_DEPTH)
    ) indexFifo (
        .clk  (clk),
        .reset(reset),
        .clear(fifoClear),
        .push (pushReq),
        .pop  (popReq),
        .din  (ADDR_W'(pixelIdx)),
        .dout (queue_out),
        .empty(fifoEmpty),
        .full (fifoFull),
        .count(fifoCount)
    );

    // DONE is entered on the same edge that leaves the FIFO empty, so
    // frame_done appears in the cycle right after the final push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pixelIdx     <= '0;
            pushedAny    <= FALSE;
            frame_done   <= FALSE;
            empty_frame  <= FALSE;
            overflow_err <= FALSE;
        end else begin
            frame_done  <= FALSE;
            empty_frame <= FALSE;
            case (state)
                IDLE: begin
                    if (frame_start && !cfg_busy) begin
                        state        <= SCAN;
                        pixelIdx     <= '0;
                        pushedAny    <= FALSE;
                        overflow_err <= FALSE;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        pixelIdx <= pixelIdx + IDX_W'(1);
                        if (pushReq) begin
                            pushedAny <= TRUE;
                        end
                        if (pushReq && fifoFull) begin
                            overflow_err <= TRUE;
                        end
                        if (pixelIdx == LAST_IDX) begin
                            if (countAfter == '0) begin
                                state       <= DONE;
                                frame_done  <= TRUE;
                                empty_frame <= !(pushedAny || pushReq);
                            end else begin
                                state <= READY;
                            end
                        end
                    end
                end
                READY: begin
                    if (popReq && (countAfter == '0)) begin
                        state      <= DONE;
                        frame_done <= TRUE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/layer1_input_sequencer.md
Name: layer1_input_sequencer

Overview:
Front-end controller for the Layer 1 accumulate pipeline. It accepts a serial pixel stream and thresholds each pixel. It enqueues the index of every active pixel into an internal FIFO and presents that FIFO to Layer 1 through the queue_out / queue_empty / inputs_ready / dequeue handshake. It also arbitrates the shared weight-storage address path against configuration writes, signalled by cfg_busy.

Parameters:
NUM_PIXELS, 784, pixels per frame
ADDR_W, 10, pixel index / queue entry width
FIFO_DEPTH, 1024, FIFO entries; must be a power of 2 and >= NUM_PIXELS
PIXEL_W, 8, input pixel width
THRESHOLD, 128, pixel is active when pixel_data >= THRESHOLD (unsigned)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
frame_start  in  1  single-cycle request to begin a new frame
pixel_valid  in  1  pixel_data valid
pixel_data  in  PIXEL_W  pixel value, raster order
pixel_ready  out  1  sequencer accepts pixel this cycle
cfg_busy  in  1  weight/bias write in progress (weightWriteEnable | biasWriteEnable)
dequeue  in  1  Layer 1 pop request
queue_out  out  ADDR_W  FIFO head (first-word fall-through)
queue_empty  out  1  no entry available to the consumer
inputs_ready  out  1  frame available for Layer 1 processing
frame_done  out  1  one-cycle pulse when the frame is fully consumed
empty_frame  out  1  one-cycle pulse with frame_done when the frame had zero active pixels
overflow_err  out  1  sticky; push attempted while FIFO full

Behaviour:
- Reset values, asynchronous: state=IDLE, FIFO pointers=0, pixel count=0. Outputs: pixel_ready=0, queue_out=0, queue_empty=1, inputs_ready=0, frame_done=0, empty_frame=0, overflow_err=0.
- Reset asserted in any state aborts the frame and discards FIFO contents.
- States:
  - IDLE: frame_start && !cfg_busy -> SCAN. This clears the pixel count, FIFO pointers and overflow_err. frame_start while cfg_busy is dropped, not queued.
  - SCAN: pixel_ready = !cfg_busy. A pixel is accepted when pixel_valid && pixel_ready. An active accepted pixel pushes the current index. The index counter (clog2(NUM_PIXELS) bits) increments on every accepted pixel. Acceptance of index NUM_PIXELS-1 -> READY, or -> DONE if the FIFO is empty after that final push.
  - READY: inputs_ready = !cfg_busy. A pop occurs at posedge when dequeue && !queue_empty && !cfg_busy. The head advances and queue_out updates in the following cycle. FIFO empty -> DONE.
  - DONE: held for one cycle. queue_empty=1 and inputs_ready=0. frame_done pulses, plus empty_frame if no pixel was pushed. -> IDLE.
- frame_start outside IDLE is ignored.
- Pop while empty is ignored; the pointers do not move and queue_out holds its value.
- Push while full: the entry is dropped and overflow_err=1. This is unreachable with legal parameters; it is tested via a forced FIFO_DEPTH override.
- Arbitration: while cfg_busy=1, no pops, no pixel acceptance and inputs_ready=0. FIFO contents are preserved. Operation resumes the cycle after cfg_busy falls.
- Latency: first pushed index appears on queue_out 1 cycle after the push. The entry count width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
STREAM_EN
- Defined: inputs_ready is allowed during SCAN when the FIFO is non-empty, so pops overlap pushes. A simultaneous push and pop leaves the entry count unchanged. Consumer-visible queue_empty = fifo_empty && scan_complete. While the FIFO is empty mid-scan, inputs_ready=0 and pops are ignored. The SCAN->DONE transition occurs when the last pixel is accepted and the FIFO is empty.
- Undefined: no pops occur before READY; the whole frame is buffered first.

Decomposition:
- Shared package/header: state encoding (IDLE, SCAN, READY, DONE), default ADDR_W, NUM_PIXELS, THRESHOLD, and the TRUE/FALSE constants already in GlobalVariables.
- Natural sub-module: index_fifo (parameterised synchronous FWFT FIFO). It exposes push, pop, din, dout, empty, full and count, with a synchronous clear used on frame_start.

Test Plan:
- Frame with pixels 3, 10 and 783 at 200 and all others at 0 -> queue_out sequence 3, 10, 783; inputs_ready during READY; frame_done one cycle after the third pop.
- All-zero frame -> inputs_ready never 1; frame_done=1 and empty_frame=1 in the same cycle, 784 accepted pixels after frame_start.
- Threshold boundary: pixels equal to 127 and 128 at indices 0 and 1 -> only index 1 is queued.
- cfg_busy held for 5 cycles mid-READY with dequeue=1 -> no pointer movement, inputs_ready=0, queue_out held; popping resumes the next cycle.
- reset asserted after 2 of 5 pops -> all outputs return to reset values immediately; the next frame starts clean with an empty FIFO.
- STREAM_EN with all 784 pixels active and dequeue held high -> count stays <= 1, indices 0..783 popped in order, frame_done 1 cycle after the last pop.
